// File: rtl/spart_rx.sv
// 8N1 serial receiver: oversampled start/data/stop detection into a holding register.
// Results visible one cycle after the stop sample; no backpressure, unread bytes are overwritten and flagged.
module spart_rx #(
    parameter int OVERSAMPLE = 16   // even, >= 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       baud_en,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       frame_err,
    output logic       overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rda_q, rda_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rxs;
    logic          load;

    assign rxs = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARM;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rda_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rda_q       <= rda_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sync1_d     = rxd;
        sync2_d     = sync1_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rda_d       = rda_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        load        = 1'b0;

        case (state_q)
            // ARM waits for a high line so a held-low break is never taken as a start bit
            ARM: begin
                if (rxs) state_d = IDLE;
            end
            IDLE: begin
                if (baud_en && !rxs) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (baud_en) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        bit_d  = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (baud_en) begin
                    if (tick_q == TICK_END) begin
                        shift_d = {rxs, shift_q[7:1]};
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (baud_en) begin
                    if (tick_q == TICK_END) begin
                        load    = 1'b1;
                        tick_d  = '0;
                        state_d = rxs ? IDLE : ARM;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = ARM;
        endcase

        // A load beats a coincident read; the read then only suppresses overrun
        if (load) begin
            rx_data_d   = shift_q;
            rda_d       = 1'b1;
            frame_err_d = ~rxs;
            overrun_d   = rda_q & ~rx_read;
        end else if (rx_read) begin
            rda_d       = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rda       = rda_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: frame-level model of expected holding-register state, checked every cycle.
module tb_spart_rx;
    logic       clk = 1'b0;
    logic       rst, rxd, baud_en, rx_read;
    logic [7:0] rx_data;
    logic       rda, frame_err, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Expected register state and the edges at which received bytes must appear
    logic       m_rda = 1'b0, m_fe = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         lq_cyc[$];
    logic [7:0] lq_dat[$];
    logic       lq_stop[$];

    // Line start to load edge: 2 sync flops + 1 to leave idle + half bit (8) + 8 data bits + stop bit
    localparam int LOAD_LAT = 2 + 1 + 8 + 8 * 16 + 16;

    spart_rx #(.OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .baud_en(baud_en), .rx_read(rx_read),
        .rx_data(rx_data), .rda(rda), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            chk_en = 1'b1;
            m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
            lq_cyc.delete(); lq_dat.delete(); lq_stop.delete();
        end else if (lq_cyc.size() > 0 && lq_cyc[0] == cyc) begin
            m_ovr  = m_rda & ~rx_read;
            m_rda  = 1'b1;
            m_data = lq_dat[0];
            m_fe   = ~lq_stop[0];
            void'(lq_cyc.pop_front()); void'(lq_dat.pop_front()); void'(lq_stop.pop_front());
        end else if (rx_read) begin
            m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rda",       {7'b0, rda},       {7'b0, m_rda});
            chk("rx_data",   rx_data,           m_data);
            chk("frame_err", {7'b0, frame_err}, {7'b0, m_fe});
            chk("overrun",   {7'b0, overrun},   {7'b0, m_ovr});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit exp_load,
                              input bit rd_at_load, input int rst_at);
        logic [9:0] bits;
        int         e0;
        bits = {stop, b, 1'b0};
        e0   = cyc;
        if (exp_load) begin
            lq_cyc.push_back(e0 + LOAD_LAT);
            lq_dat.push_back(b);
            lq_stop.push_back(stop);
        end
        for (int t = 0; t < 160; t++) begin
            rxd     = bits[t / 16];
            rx_read = rd_at_load && (t == LOAD_LAT - 1);
            rst     = (t == rst_at);
            @(posedge clk); #1;
        end
        rxd = 1'b1; rx_read = 1'b0; rst = 1'b0;
    endtask

    task automatic read_pulse();
        rx_read = 1'b1;
        @(posedge clk); #1;
        rx_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; baud_en = 1'b1; rx_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset rda",     {7'b0, rda},       8'h00);
        chk("reset rx_data", rx_data,           8'h00);
        chk("reset fe",      {7'b0, frame_err}, 8'h00);
        chk("reset ovr",     {7'b0, overrun},   8'h00);
        idle(3);

        send_frame(8'h68, 1'b1, 1'b1, 1'b0, -1);
        chk("nominal data", rx_data,           8'h68);
        chk("nominal rda",  {7'b0, rda},       8'h01);
        chk("nominal fe",   {7'b0, frame_err}, 8'h00);
        chk("nominal ovr",  {7'b0, overrun},   8'h00);

        idle(20);
        read_pulse();
        chk("read clears rda", {7'b0, rda}, 8'h00);
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        chk("glitch no load", {7'b0, rda}, 8'h00);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, -1);
        chk("after glitch data", rx_data, 8'h55);

        idle(16);
        read_pulse();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);
        rxd = 1'b0;
        idle(40);
        rxd = 1'b1;
        idle(20);
        chk("framing data", rx_data,           8'hA5);
        chk("framing fe",   {7'b0, frame_err}, 8'h01);
        chk("framing rda",  {7'b0, rda},       8'h01);
        read_pulse();

        idle(16);
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, -1);
        idle(16);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, -1);
        chk("overrun data", rx_data,         8'h22);
        chk("overrun flag", {7'b0, overrun}, 8'h01);
        read_pulse();
        chk("read rda",  {7'b0, rda},       8'h00);
        chk("read ovr",  {7'b0, overrun},   8'h00);
        chk("read fe",   {7'b0, frame_err}, 8'h00);
        chk("read keeps data", rx_data,     8'h22);
        idle(16);
        send_frame(8'h33, 1'b1, 1'b1, 1'b1, -1);
        chk("read@load rda",  {7'b0, rda},     8'h01);
        chk("read@load ovr",  {7'b0, overrun}, 8'h00);
        chk("read@load data", rx_data,         8'h33);

        idle(16);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 70);
        idle(20);
        chk("midframe rst rda",  {7'b0, rda}, 8'h00);
        chk("midframe rst data", rx_data,     8'h00);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, -1);
        chk("post rst data", rx_data,     8'h3C);
        chk("post rst rda",  {7'b0, rda}, 8'h01);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
